// File: rtl/poli_spi_cmd_bridge_pkg.sv
// Shared POLI types: register-select map, SPI bridge FSM states and command framing constants.
package POLI_types_pkg;

  // Control register file map; register_select carries one of these codes.
  typedef enum logic [3:0] {
    REG_CTRL   = 4'h0,
    REG_STATUS = 4'h1,
    REG_CFG0   = 4'h2,
    REG_CFG1   = 4'h3,
    REG_IRQ_EN = 4'h4,
    REG_IRQ_ST = 4'h5,
    REG_TEST   = 4'hF
  } reg_sel_t;

  localparam int REG_SEL_W = $bits(reg_sel_t);

  // SPI command bridge FSM states.
  typedef enum logic [2:0] {
    SPI_IDLE  = 3'd0,
    SPI_CMD   = 3'd1,
    SPI_WDATA = 3'd2,
    SPI_RLOAD = 3'd3,
    SPI_RDATA = 3'd4,
    SPI_DONE  = 3'd5
  } spi_state_t;

  localparam int SPI_CMD_WRITE_BIT = 7;
  localparam int SPI_CMD_BITS      = 8;

endpackage

// File: rtl/poli_spi_cmd_bridge_if.sv
// Pad-side SPI pins plus the register-bus initiator signals of the command bridge.
interface poli_spi_cmd_bridge_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic              spi_sck;
  logic              spi_cs_n;
  logic              spi_mosi;
  logic              spi_miso;
  logic [ADDR_W-1:0] register_select;
  logic              write_enable;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic              busy;
  logic              frame_error;

  // Bridge side: SPI slave, register-bus initiator.
  modport slave (
    input  spi_sck, spi_cs_n, spi_mosi, read_data,
    output spi_miso, register_select, write_enable, write_data, busy, frame_error
  );

  // Tester / register-file side.
  modport master (
    output spi_sck, spi_cs_n, spi_mosi, read_data,
    input  spi_miso, register_select, write_enable, write_data, busy, frame_error
  );
endinterface

// File: rtl/poli_spi_cmd_bridge_sync_edge.sv
// poli_sync_edge: N-flop synchronizer with a 1-flop history giving rise/fall pulses.
// Pulses are valid STAGES CLKs after the pin moves and get acted on one CLK later.
module poli_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic nRST,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync;
  logic              hist;

  // Shift the pin through the synchronizer and keep one sample of history.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sync <= '0;
      hist <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      hist <= sync[STAGES-1];
    end
  end

  assign rise =  sync[STAGES-1] & ~hist;
  assign fall = ~sync[STAGES-1] &  hist;
endmodule

// File: rtl/poli_spi_cmd_bridge.sv
// SPI-slave command bridge: decodes framed SPI commands into register-bus
// writes and shifts register reads back out on MISO. SPI pins are oversampled on CLK.
module poli_spi_cmd_bridge
  import POLI_types_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = REG_SEL_W,
  parameter int DATA_W      = 32
) (
  input  logic                  CLK,
  input  logic                  nRST,
  poli_spi_cmd_bridge_if.slave  bus
);
  localparam logic [2:0] S_IDLE  = SPI_IDLE;
  localparam logic [2:0] S_CMD   = SPI_CMD;
  localparam logic [2:0] S_WDATA = SPI_WDATA;
  localparam logic [2:0] S_RLOAD = SPI_RLOAD;
  localparam logic [2:0] S_RDATA = SPI_RDATA;
  localparam logic [2:0] S_DONE  = SPI_DONE;

  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] CMD_LAST  = CW'(SPI_CMD_BITS - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);

  logic [2:0]             state;
  logic [CW-1:0]          bitcnt;
  logic [DATA_W-1:0]      rx_shift, rx_next, tx_shift;
  logic                   skip_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   mosi_s;
  logic                   sck_rise, sck_fall, cs_rise, cs_fall;

  poli_sync_edge #(.STAGES(SYNC_STAGES)) u_sck (
    .CLK(CLK), .nRST(nRST), .d(bus.spi_sck), .rise(sck_rise), .fall(sck_fall)
  );

  poli_sync_edge #(.STAGES(SYNC_STAGES)) u_cs (
    .CLK(CLK), .nRST(nRST), .d(bus.spi_cs_n), .rise(cs_rise), .fall(cs_fall)
  );

  // MOSI uses the same depth as SCK so a detected rise lines up with its data bit.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) mosi_sync <= '0;
    else       mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
  end

  assign mosi_s  = mosi_sync[SYNC_STAGES-1];
  assign rx_next = {rx_shift[DATA_W-2:0], mosi_s};

  // Frame FSM: command byte, then write data in or read data out; cs_n rise always wins.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state               <= S_IDLE;
      bitcnt              <= '0;
      rx_shift            <= '0;
      tx_shift            <= '0;
      skip_fall           <= 1'b0;
      bus.register_select <= '0;
      bus.write_data      <= '0;
      bus.write_enable    <= 1'b0;
      bus.frame_error     <= 1'b0;
    end else begin
      bus.write_enable <= 1'b0;
      bus.frame_error  <= 1'b0;
      if (state != S_IDLE && cs_rise) begin
        state           <= S_IDLE;
        bus.frame_error <= (state inside {S_CMD, S_WDATA, S_RLOAD, S_RDATA});
      end else begin
        case (state)
          S_IDLE: begin
            if (cs_fall) begin
              state  <= S_CMD;
              bitcnt <= '0;
            end
          end
          S_CMD: begin
            if (sck_rise) begin
              rx_shift <= rx_next;
              bitcnt   <= bitcnt + 1'b1;
              if (bitcnt == CMD_LAST) begin
                bus.register_select <= rx_next[ADDR_W-1:0];
                bitcnt              <= '0;
                state               <= rx_next[SPI_CMD_WRITE_BIT] ? S_WDATA : S_RLOAD;
              end
            end
          end
          S_WDATA: begin
            if (sck_rise) begin
              rx_shift <= rx_next;
              bitcnt   <= bitcnt + 1'b1;
              if (bitcnt == DATA_LAST) begin
                bus.write_data   <= rx_next;
                bus.write_enable <= 1'b1;
                state            <= S_DONE;
              end
            end
          end
          S_RLOAD: begin
            tx_shift  <= bus.read_data;
            skip_fall <= 1'b1;
            bitcnt    <= '0;
            state     <= S_RDATA;
          end
          S_RDATA: begin
            // The fall closing the command byte must leave the MSB on the pin.
            if (sck_fall) begin
              if (skip_fall) skip_fall <= 1'b0;
              else           tx_shift  <= {tx_shift[DATA_W-2:0], 1'b0};
            end
            if (sck_rise) begin
              bitcnt <= bitcnt + 1'b1;
              if (bitcnt == DATA_LAST) state <= S_DONE;
            end
          end
          S_DONE: ;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.busy     = (state != S_IDLE);
  assign bus.spi_miso = (state == S_RDATA) & ~bus.spi_cs_n & tx_shift[DATA_W-1];
endmodule

// File: tb/tb_poli_spi_cmd_bridge.sv
// Directed + randomized bench for poli_spi_cmd_bridge with a frame-level reference model.
module tb_poli_spi_cmd_bridge;
  localparam int AW = 4;
  localparam int DW = 32;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  poli_spi_cmd_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  poli_spi_cmd_bridge #(.SYNC_STAGES(2), .ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(CLK), .nRST(nRST), .bus(bus)
  );

  // Emulated register file (written by DUT strobes) and the model's own copy.
  logic [DW-1:0] rf  [16];
  logic [DW-1:0] mdl [16];
  assign bus.read_data = rf[bus.register_select];

  int ncomp = 0, nfail = 0;
  int we_cnt = 0, fe_cnt = 0, exp_we = 0, exp_fe = 0;
  logic [AW-1:0] exp_sel = '0;
  logic [DW-1:0] exp_wd  = '0;
  logic [DW-1:0] mw;

  // Count strobes; a stretched write_enable shows up as an extra write.
  always @(posedge CLK) begin
    if (bus.write_enable) begin
      we_cnt++;
      rf[bus.register_select] = bus.write_data;
    end
    if (bus.frame_error) fe_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Clock nbits SCK cycles (mode 0, CLK/8) after cs_n fall; capture MISO before each data rise.
  task automatic frame(input logic [7:0] cmd, input logic [31:0] data, input int nbits,
                       input bit end_cs, output logic [31:0] miso_w);
    logic [39:0] bits;
    bits   = {cmd, data};
    miso_w = '0;
    bus.spi_cs_n = 1'b0;
    tick(4);
    chk("busy_start", 64'(bus.busy), 64'd1);
    for (int i = 0; i < nbits; i++) begin
      bus.spi_mosi = (i < 40) ? bits[39-i] : 1'($urandom);
      tick(4);
      if (i >= 8 && i < 40) miso_w[39-i] = bus.spi_miso;
      bus.spi_sck = 1'b1;
      tick(4);
      bus.spi_sck = 1'b0;
    end
    tick(4);
    if (end_cs) begin
      bus.spi_cs_n = 1'b1;
      bus.spi_mosi = 1'b0;
      tick(20);
    end
  endtask

  // Full frame plus model update and checks of every visible effect.
  task automatic run(input string tag, input logic [7:0] cmd, input logic [31:0] data, input int nbits);
    logic [31:0] m;
    frame(cmd, data, nbits, 1'b1, m);
    if (nbits >= 8) exp_sel = cmd[3:0];
    if (nbits < 40) exp_fe++;
    else if (cmd[7]) begin
      exp_we++;
      exp_wd = data;
      mdl[cmd[3:0]] = data;
    end
    chk({tag, "_we_cnt"}, 64'(we_cnt), 64'(exp_we));
    chk({tag, "_fe_cnt"}, 64'(fe_cnt), 64'(exp_fe));
    chk({tag, "_sel"},    64'(bus.register_select), 64'(exp_sel));
    chk({tag, "_wdata"},  64'(bus.write_data), 64'(exp_wd));
    chk({tag, "_busy"},   64'(bus.busy), 64'd0);
    chk({tag, "_miso_idle"}, 64'(bus.spi_miso), 64'd0);
    if (!cmd[7] && nbits >= 40) chk({tag, "_miso"}, 64'(m), 64'(mdl[cmd[3:0]]));
  endtask

  initial begin
    bus.spi_sck  = 1'b0;
    bus.spi_cs_n = 1'b1;
    bus.spi_mosi = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rf[i]  = $urandom;
      mdl[i] = rf[i];
    end
    rf[5]  = 32'h12345678;
    mdl[5] = 32'h12345678;

    // Reset state
    tick(3);
    chk("rst_sel",   64'(bus.register_select), 64'd0);
    chk("rst_wdata", 64'(bus.write_data), 64'd0);
    chk("rst_we",    64'(bus.write_enable), 64'd0);
    chk("rst_fe",    64'(bus.frame_error), 64'd0);
    chk("rst_busy",  64'(bus.busy), 64'd0);
    chk("rst_miso",  64'(bus.spi_miso), 64'd0);
    nRST = 1'b1;
    tick(10);

    run("wr",    8'h8A, 32'hDEADBEEF, 40);
    run("rd",    8'h05, 32'h0,        40);
    run("abort", 8'h83, 32'hABC00000, 20);
    run("ovr",   8'h8C, 32'h0000FFFF, 56);

    // Async reset in the middle of a write frame
    frame(8'h81, 32'h11112222, 20, 1'b0, mw);
    nRST = 1'b0;
    tick(2);
    chk("mid_rst_sel",   64'(bus.register_select), 64'd0);
    chk("mid_rst_wdata", 64'(bus.write_data), 64'd0);
    chk("mid_rst_we",    64'(bus.write_enable), 64'd0);
    chk("mid_rst_fe",    64'(bus.frame_error), 64'd0);
    chk("mid_rst_busy",  64'(bus.busy), 64'd0);
    chk("mid_rst_miso",  64'(bus.spi_miso), 64'd0);
    bus.spi_cs_n = 1'b1;
    tick(2);
    nRST = 1'b1;
    tick(20);
    exp_sel = '0;
    exp_wd  = '0;
    chk("post_rst_we_cnt", 64'(we_cnt), 64'(exp_we));
    chk("post_rst_fe_cnt", 64'(fe_cnt), 64'(exp_fe));
    run("rst_wr", 8'h82, 32'hA5A5A5A5, 40);

    // Back-to-back write then read-back through the register file
    run("b2b_wr", 8'h87, 32'hCAFEF00D, 40);
    run("b2b_rd", 8'h07, 32'h0,        40);
    chk("b2b_value", 64'(mdl[7]), 64'h00000000CAFEF00D);

    // Randomized frames: mix of complete, aborted and overrun reads/writes
    for (int k = 0; k < 16; k++) begin
      logic [7:0]  c;
      logic [31:0] d;
      int          nb;
      int          r;
      c = 8'($urandom);
      d = $urandom;
      r = int'($urandom_range(0, 3));
      if (r == 0)      nb = int'($urandom_range(1, 39));
      else if (r == 3) nb = 40 + int'($urandom_range(1, 16));
      else             nb = 40;
      run("rand", c, d, nb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end
endmodule
